// File: rtl/sync_gen_param_if.sv
// Video timing bundle between the sync generator (master) and the pixel pipeline (slave).
// The enable travels with the timing signals because every consumer must qualify strobes with it.
interface sync_gen_param_if #(
    parameter int X_W     = 11,
    parameter int Y_W     = 11,
    parameter int FRAME_W = 8
) ();
    logic               en;
    logic               vga_h_sync;
    logic               vga_v_sync;
    logic               inDisplayArea;
    logic               inPrefetchArea;
    logic [X_W-1:0]     prefetchCounterX;
    logic [Y_W-1:0]     counterY;
    logic               lineStart;
    logic               frameStart;
    logic [FRAME_W-1:0] frameCounter;

    modport master (
        input  en,
        output vga_h_sync, vga_v_sync, inDisplayArea, inPrefetchArea,
        output prefetchCounterX, counterY, lineStart, frameStart, frameCounter
    );

    modport slave (
        output en,
        input  vga_h_sync, vga_v_sync, inDisplayArea, inPrefetchArea,
        input  prefetchCounterX, counterY, lineStart, frameStart, frameCounter
    );
endinterface

// File: rtl/sync_gen_param.sv
// Parametrised VGA/VESA timing generator: beam counters plus registered sync, area flags and strobes.
// A prefetch X counter runs PREFETCH clocks ahead of the beam so fetch logic can lead the display.
module sync_gen_param #(
    parameter int H_VISIBLE = 1280,
    parameter int H_FRONT   = 48,
    parameter int H_SYNC    = 112,
    parameter int H_BACK    = 248,
    parameter int V_VISIBLE = 1024,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 38,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1,
    parameter int PREFETCH  = 16,
    parameter int X_W       = 11,
    parameter int Y_W       = 11,
    parameter int FRAME_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    sync_gen_param_if.master  vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int X_START = H_SYNC + H_BACK;
    localparam int PF_INIT = (PREFETCH == X_START) ? 0 : (H_TOTAL - X_START + PREFETCH);

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_SYNC);
    localparam logic [X_W-1:0] X_BEGIN    = X_W'(X_START);
    localparam logic [X_W-1:0] X_END      = X_W'(X_START + H_VISIBLE);
    localparam logic [X_W-1:0] H_VIS      = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0] PF_START   = X_W'(PF_INIT);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_VIS      = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic           HP         = 1'(H_POL);
    localparam logic           VP         = 1'(V_POL);

    logic [X_W-1:0]     counterX;
    logic [X_W-1:0]     pfX;
    logic [Y_W-1:0]     yPos;
    logic [FRAME_W-1:0] frameCnt;

    logic xWrap, yWrap;
    logic hActive, vActive, yVisible, dispNext, prefNext, lineNext, frameNext;

    always_comb begin
        xWrap     = (counterX == H_LAST);
        yWrap     = (yPos == V_LAST);
        yVisible  = (yPos < V_VIS);
        hActive   = (counterX < H_SYNC_END);
        vActive   = (yPos >= V_SYNC_BEG) && (yPos < V_SYNC_END);
        dispNext  = (counterX >= X_BEGIN) && (counterX < X_END) && yVisible;
        prefNext  = (pfX < H_VIS) && yVisible;
        lineNext  = (counterX == X_BEGIN) && yVisible;
        frameNext = (counterX == X_BEGIN) && (yPos == '0);
    end

    // pfX tracks counterX shifted by the prefetch lead, wrapping on its own instead of using a modulo.
    always_ff @(posedge clk) begin
        if (rst) begin
            counterX             <= '0;
            pfX                  <= PF_START;
            yPos                 <= '0;
            frameCnt             <= '0;
            vga.vga_h_sync       <= ~HP;
            vga.vga_v_sync       <= ~VP;
            vga.inDisplayArea    <= 1'b0;
            vga.inPrefetchArea   <= 1'b0;
            vga.prefetchCounterX <= '0;
            vga.counterY         <= '0;
            vga.lineStart        <= 1'b0;
            vga.frameStart       <= 1'b0;
            vga.frameCounter     <= '0;
        end else if (vga.en) begin
            counterX <= xWrap ? '0 : counterX + 1'b1;
            pfX      <= (pfX == H_LAST) ? '0 : pfX + 1'b1;
            if (xWrap) begin
                yPos <= yWrap ? '0 : yPos + 1'b1;
                if (yWrap) begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
            vga.vga_h_sync       <= hActive ? HP : ~HP;
            vga.vga_v_sync       <= vActive ? VP : ~VP;
            vga.inDisplayArea    <= dispNext;
            vga.inPrefetchArea   <= prefNext;
            vga.prefetchCounterX <= pfX;
            vga.counterY         <= yPos;
            vga.lineStart        <= lineNext;
            vga.frameStart       <= frameNext;
            vga.frameCounter     <= frameCnt;
        end
    end
endmodule

// File: tb/tb_sync_gen_param.sv
// Directed bench for sync_gen_param on a tiny 14x7 mode: table of hand-computed output vectors
// plus sequences for frame counts, polarity, clock-enable stalls and mid-frame reset.
module tb_sync_gen_param;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_gen_param_if #(.X_W(4), .Y_W(3), .FRAME_W(2)) vif ();
    sync_gen_param_if #(.X_W(4), .Y_W(3), .FRAME_W(2)) vifN ();

    sync_gen_param #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1), .V_POL(1), .PREFETCH(1),
        .X_W(4), .Y_W(3), .FRAME_W(2)
    ) dut (.clk(clk), .rst(rst), .vga(vif.master));

    sync_gen_param #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(0), .V_POL(0), .PREFETCH(1),
        .X_W(4), .Y_W(3), .FRAME_W(2)
    ) dutN (.clk(clk), .rst(rst), .vga(vifN.master));

    typedef struct {
        int n;
        int hs, vs, disp, pref, pfx, cy, ls, fs, fc;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;
    int   tickTotal = 0;

    int hsCnt, vsCnt, hsLowN, vsLowN, lsCnt, fsCnt, dispCnt, prefCnt;
    int dispRun, prefRun, dispMax, prefMax, pfExp, pfBad, prefRise, dispRise;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        hsCnt = 0; vsCnt = 0; hsLowN = 0; vsLowN = 0; lsCnt = 0; fsCnt = 0;
        dispCnt = 0; prefCnt = 0; dispRun = 0; prefRun = 0; dispMax = 0; prefMax = 0;
        pfExp = 0; pfBad = 0; prefRise = -1; dispRise = -1;
    endtask

    // One clock; statistics only accumulate on enabled edges since disabled edges merely hold.
    task automatic tick(input logic e);
        vif.en  = e;
        vifN.en = e;
        @(posedge clk);
        #1;
        tickTotal++;
        if (e) begin
            n++;
            hsCnt  += int'(vif.vga_h_sync);
            vsCnt  += int'(vif.vga_v_sync);
            hsLowN += int'(!vifN.vga_h_sync);
            vsLowN += int'(!vifN.vga_v_sync);
            lsCnt  += int'(vif.lineStart);
            fsCnt  += int'(vif.frameStart);
            if (vif.inDisplayArea) begin
                dispCnt++; dispRun++;
                if (dispRise < 0) dispRise = n;
            end else dispRun = 0;
            if (vif.inPrefetchArea) begin
                prefCnt++; prefRun++;
                if (prefRise < 0) prefRise = n;
                if (int'(vif.prefetchCounterX) != pfExp) pfBad++;
                pfExp++;
            end else begin
                prefRun = 0;
                pfExp = 0;
            end
            if (dispRun > dispMax) dispMax = dispRun;
            if (prefRun > prefMax) prefMax = prefRun;
        end
    endtask

    task automatic applyStimulus(input int target);
        while (n < target) tick(1'b1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        vif.en = 1'b1;
        vifN.en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        clearCounts();
    endtask

    task automatic checkVec(input vec_t v);
        string t;
        t = $sformatf("n%0d", v.n);
        checkOutput({t, " hsync"}, int'(vif.vga_h_sync), v.hs);
        checkOutput({t, " vsync"}, int'(vif.vga_v_sync), v.vs);
        checkOutput({t, " disp"},  int'(vif.inDisplayArea), v.disp);
        checkOutput({t, " pref"},  int'(vif.inPrefetchArea), v.pref);
        checkOutput({t, " pfx"},   int'(vif.prefetchCounterX), v.pfx);
        checkOutput({t, " cy"},    int'(vif.counterY), v.cy);
        checkOutput({t, " lineStart"},  int'(vif.lineStart), v.ls);
        checkOutput({t, " frameStart"}, int'(vif.frameStart), v.fs);
        checkOutput({t, " frameCnt"},   int'(vif.frameCounter), v.fc);
    endtask

    initial begin
        vif.en  = 1'b1;
        vifN.en = 1'b1;

        //            n   hs vs di pr pfx cy ls fs fc
        vecs.push_back('{  1, 1, 0, 0, 0, 11, 0, 0, 0, 0});
        vecs.push_back('{  3, 0, 0, 0, 0, 13, 0, 0, 0, 0});
        vecs.push_back('{  4, 0, 0, 0, 1,  0, 0, 0, 0, 0});
        vecs.push_back('{  5, 0, 0, 1, 1,  1, 0, 1, 1, 0});
        vecs.push_back('{ 12, 0, 0, 1, 0,  8, 0, 0, 0, 0});
        vecs.push_back('{ 13, 0, 0, 0, 0,  9, 0, 0, 0, 0});
        vecs.push_back('{ 19, 0, 0, 1, 1,  1, 1, 1, 0, 0});
        vecs.push_back('{ 61, 0, 0, 0, 0,  1, 4, 0, 0, 0});
        vecs.push_back('{ 71, 1, 1, 0, 0, 11, 5, 0, 0, 0});
        vecs.push_back('{ 85, 1, 0, 0, 0, 11, 6, 0, 0, 0});
        vecs.push_back('{ 98, 0, 0, 0, 0, 10, 6, 0, 0, 0});
        vecs.push_back('{ 99, 1, 0, 0, 0, 11, 0, 0, 0, 1});
        vecs.push_back('{103, 0, 0, 1, 1,  1, 0, 1, 1, 1});
        vecs.push_back('{197, 1, 0, 0, 0, 11, 0, 0, 0, 2});
        vecs.push_back('{295, 1, 0, 0, 0, 11, 0, 0, 0, 3});
        vecs.push_back('{393, 1, 0, 0, 0, 11, 0, 0, 0, 0});

        // Reset values, sampled while rst is still asserted.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst hsync",    int'(vif.vga_h_sync), 0);
        checkOutput("rst vsync",    int'(vif.vga_v_sync), 0);
        checkOutput("rst disp",     int'(vif.inDisplayArea), 0);
        checkOutput("rst pref",     int'(vif.inPrefetchArea), 0);
        checkOutput("rst pfx",      int'(vif.prefetchCounterX), 0);
        checkOutput("rst lineStart", int'(vif.lineStart), 0);
        checkOutput("rst frameCnt", int'(vif.frameCounter), 0);
        checkOutput("rst hsyncN",   int'(vifN.vga_h_sync), 1);
        checkOutput("rst vsyncN",   int'(vifN.vga_v_sync), 1);
        rst = 1'b0;
        n = 0;
        clearCounts();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].n);
            checkVec(vecs[i]);
        end

        // One whole frame of statistics, starting at a frame boundary.
        clearCounts();
        applyStimulus(393 + 98);
        checkOutput("frame hsync highs",  hsCnt, 14);
        checkOutput("frame vsync highs",  vsCnt, 14);
        checkOutput("frame hsyncN lows",  hsLowN, 14);
        checkOutput("frame vsyncN lows",  vsLowN, 14);
        checkOutput("frame lineStarts",   lsCnt, 4);
        checkOutput("frame frameStarts",  fsCnt, 1);
        checkOutput("frame disp clocks",  dispCnt, 32);
        checkOutput("frame pref clocks",  prefCnt, 32);
        checkOutput("disp run length",    dispMax, 8);
        checkOutput("pref run length",    prefMax, 8);
        checkOutput("pref lead",          dispRise - prefRise, 1);
        checkOutput("pfx sequence errors", pfBad, 0);

        // Clock-enable stall in the middle of the first visible line.
        doReset();
        applyStimulus(3);
        clearCounts();
        applyStimulus(5);
        checkOutput("en frameStart", int'(vif.frameStart), 1);
        tickTotal = 0;
        applyStimulus(7);
        repeat (5) tick(1'b0);
        checkOutput("hold disp", int'(vif.inDisplayArea), 1);
        checkOutput("hold pref", int'(vif.inPrefetchArea), 1);
        checkOutput("hold pfx",  int'(vif.prefetchCounterX), 3);
        checkOutput("hold hsync", int'(vif.vga_h_sync), 0);
        checkOutput("hold lineStart", int'(vif.lineStart), 0);
        applyStimulus(17);
        checkOutput("en disp clocks", dispCnt, 8);
        checkOutput("en disp run", dispMax, 8);
        applyStimulus(103);
        checkOutput("en frameStart again", int'(vif.frameStart), 1);
        checkOutput("en frame period", tickTotal, 103);

        // Mid-frame reset at line 2, X 6 of the second frame.
        doReset();
        applyStimulus(132);
        checkOutput("pre-rst frameCnt", int'(vif.frameCounter), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst hsync", int'(vif.vga_h_sync), 0);
        checkOutput("midrst disp",  int'(vif.inDisplayArea), 0);
        checkOutput("midrst cy",    int'(vif.counterY), 0);
        checkOutput("midrst pfx",   int'(vif.prefetchCounterX), 0);
        checkOutput("midrst frameCnt", int'(vif.frameCounter), 0);
        rst = 1'b0;
        n = 0;
        applyStimulus(1);
        checkOutput("restart hsync", int'(vif.vga_h_sync), 1);
        checkOutput("restart pfx",   int'(vif.prefetchCounterX), 11);
        checkOutput("restart cy",    int'(vif.counterY), 0);
        applyStimulus(5);
        checkOutput("restart frameStart", int'(vif.frameStart), 1);
        checkOutput("restart frameCnt",   int'(vif.frameCounter), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
